// File: rtl/machine_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : machine_dispatcher                                            |
// | Purpose  : Round-robin dispatch of machine descriptors to a worker array |
// |            and in-order-of-completion retirement of their press counts   |
// |            into a saturating puzzle total.                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module machine_dispatcher #(
  parameter int NUM_WORKERS = 4,
  parameter int PRESSES_W   = 5,
  parameter int SUM_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  output logic [NUM_WORKERS-1:0]         worker_load,
  output logic [NUM_WORKERS-1:0]         worker_start,
  input  logic [NUM_WORKERS-1:0]         worker_ready,
  input  logic [NUM_WORKERS*PRESSES_W-1:0] worker_presses,
  output logic [NUM_WORKERS-1:0]         worker_accepted,
  output logic [SUM_W-1:0]               total_presses,
  output logic [SUM_W-1:0]               machines_done,
  output logic                           busy,
  output logic                           done
);

  localparam int PTR_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int ACC_W = ((SUM_W > PRESSES_W) ? SUM_W : PRESSES_W) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  localparam logic [1:0] TOP_IDLE  = 2'd0;
  localparam logic [1:0] TOP_RUN   = 2'd1;
  localparam logic [1:0] TOP_FLUSH = 2'd2;
  localparam logic [1:0] TOP_DONE  = 2'd3;

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_RUN   = 2'd1;
  localparam logic [1:0] W_DRAIN = 2'd2;

  logic [1:0]             top_state;
  logic [1:0]             top_next;
  logic [1:0]             wstate [NUM_WORKERS];
  logic [PTR_W-1:0]       disp_ptr;
  logic [PTR_W-1:0]       coll_ptr;
  logic                   out_en;

  logic [NUM_WORKERS-1:0] w_idle;
  logic [NUM_WORKERS-1:0] coll_cand;
  logic [NUM_WORKERS-1:0] coll_onehot;
  logic [PRESSES_W-1:0]   presses_arr [NUM_WORKERS];
  logic                   all_idle;
  logic                   disp_found;
  logic [PTR_W-1:0]       disp_sel;
  logic                   coll_found;
  logic [PTR_W-1:0]       coll_sel;
  logic                   handshake;
  logic [ACC_W-1:0]       sum_wide;
  logic [SUM_W-1:0]       total_sat;
  logic [SUM_W-1:0]       count_sat;

  // Pointer arithmetic modulo NUM_WORKERS; off is always below NUM_WORKERS,
  // so a single conditional subtraction wraps correctly.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base, input int off);
    logic [PTR_W:0] s;
    s = {1'b0, base} + (PTR_W+1)'(off);
    if (s >= (PTR_W+1)'(NUM_WORKERS)) s = s - (PTR_W+1)'(NUM_WORKERS);
    return s[PTR_W-1:0];
  endfunction

  for (genvar gi = 0; gi < NUM_WORKERS; gi++) begin : g_slot
    assign presses_arr[gi] = worker_presses[gi*PRESSES_W +: PRESSES_W];
    assign w_idle[gi]      = (wstate[gi] == W_IDLE);
    assign coll_cand[gi]   = (wstate[gi] == W_RUN) && worker_ready[gi];
  end

  assign all_idle  = &w_idle;
  // out_en keeps in_ready low through the first cycle after reset.
  assign in_ready  = out_en && ((top_state == TOP_IDLE) || (top_state == TOP_RUN)) && disp_found;
  assign handshake = in_valid && in_ready;

  // Round-robin pick of the first IDLE worker at or after disp_ptr.
  always_comb begin
    disp_found = 1'b0;
    disp_sel   = '0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      if (!disp_found && w_idle[ptr_add(disp_ptr, k)]) begin
        disp_found = 1'b1;
        disp_sel   = ptr_add(disp_ptr, k);
      end
    end
  end

  // Round-robin pick of the first finished RUN worker at or after coll_ptr.
  always_comb begin
    coll_found = 1'b0;
    coll_sel   = '0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      if (!coll_found && coll_cand[ptr_add(coll_ptr, k)]) begin
        coll_found = 1'b1;
        coll_sel   = ptr_add(coll_ptr, k);
      end
    end
  end

  // Expand the two arbiter winners into one-hot strobes.
  always_comb begin
    worker_load = '0;
    coll_onehot = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      worker_load[i] = handshake && (disp_sel == PTR_W'(i));
      coll_onehot[i] = coll_found && (coll_sel == PTR_W'(i));
    end
  end

  // Saturating accumulators; the extra bit of sum_wide catches overflow.
  assign sum_wide  = ACC_W'(total_presses) + ACC_W'(presses_arr[coll_sel]);
  assign total_sat = (sum_wide > ACC_W'(SUM_MAX)) ? SUM_MAX : sum_wide[SUM_W-1:0];
  assign count_sat = (machines_done == SUM_MAX) ? SUM_MAX : machines_done + SUM_W'(1);

  // Top-level sequencing: accept descriptors, then flush until all workers drain.
  always_comb begin
    top_next = top_state;
    case (top_state)
      TOP_IDLE:  if (handshake) top_next = in_last ? TOP_FLUSH : TOP_RUN;
      TOP_RUN:   if (handshake && in_last) top_next = TOP_FLUSH;
      TOP_FLUSH: if (all_idle) top_next = TOP_DONE;
      TOP_DONE:  top_next = TOP_IDLE;
      default:   top_next = TOP_IDLE;
    endcase
  end

  // Per-worker slot state; DRAIN waits out the worker's lingering ready.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WORKERS; i++) begin
      if (!rst_n) begin
        wstate[i] <= W_IDLE;
      end else begin
        case (wstate[i])
          W_IDLE:  if (worker_load[i])   wstate[i] <= W_RUN;
          W_RUN:   if (coll_onehot[i])   wstate[i] <= W_DRAIN;
          W_DRAIN: if (!worker_ready[i]) wstate[i] <= W_IDLE;
          default: wstate[i] <= W_IDLE;
        endcase
      end
    end
  end

  // Top state, pointers, registered strobes and accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      top_state       <= TOP_IDLE;
      out_en          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      worker_start    <= '0;
      worker_accepted <= '0;
      disp_ptr        <= '0;
      coll_ptr        <= '0;
      total_presses   <= '0;
      machines_done   <= '0;
    end else begin
      top_state       <= top_next;
      out_en          <= 1'b1;
      busy            <= (top_next != TOP_IDLE);
      done            <= (top_next == TOP_DONE);
      worker_start    <= worker_load;
      worker_accepted <= coll_onehot;
      if (handshake)  disp_ptr <= ptr_add(disp_sel, 1);
      if (coll_found) coll_ptr <= ptr_add(coll_sel, 1);
      // A new puzzle starts from zero; in IDLE no worker can be collecting.
      if ((top_state == TOP_IDLE) && handshake) begin
        total_presses <= '0;
        machines_done <= '0;
      end else if (coll_found) begin
        total_presses <= total_sat;
        machines_done <= count_sat;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_machine_dispatcher.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_machine_dispatcher                                         |
// | Purpose  : Directed self-checking bench for machine_dispatcher with     |
// |            behavioural worker models (4-worker and 2-worker/4-bit DUTs). |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_machine_dispatcher;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // ---------------- DUT A: 4 workers, 16-bit sums ----------------
  logic        va = 1'b0, la = 1'b0, rdy_a;
  logic [3:0]  load_a, start_a, wrdy_a, acc_a, acc_prev_a;
  logic [19:0] prs_bus_a;
  logic [15:0] total_a, md_a;
  logic        busy_a, done_a;
  logic [4:0]  cur_prs_a = '0;
  int          cur_lat_a = 0;

  machine_dispatcher #(.NUM_WORKERS(4), .PRESSES_W(5), .SUM_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(rdy_a), .in_last(la),
    .worker_load(load_a), .worker_start(start_a), .worker_ready(wrdy_a),
    .worker_presses(prs_bus_a), .worker_accepted(acc_a),
    .total_presses(total_a), .machines_done(md_a), .busy(busy_a), .done(done_a));

  // ---------------- DUT B: 2 workers, 4-bit sums ----------------
  logic        vb = 1'b0, lb = 1'b0, rdy_b;
  logic [1:0]  load_b, start_b, wrdy_b, acc_b;
  logic [9:0]  prs_bus_b;
  logic [3:0]  total_b, md_b;
  logic        busy_b, done_b;
  logic [4:0]  cur_prs_b = '0;
  int          cur_lat_b = 0;

  machine_dispatcher #(.NUM_WORKERS(2), .PRESSES_W(5), .SUM_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(rdy_b), .in_last(lb),
    .worker_load(load_b), .worker_start(start_b), .worker_ready(wrdy_b),
    .worker_presses(prs_bus_b), .worker_accepted(acc_b),
    .total_presses(total_b), .machines_done(md_b), .busy(busy_b), .done(done_b));

  // Worker models: latch descriptor on load, count latency after start,
  // then hold ready through the accepted cycle and one more cycle.
  int         cnt_a [4];
  int         lat_q_a [4];
  logic [4:0] prs_q_a [4];
  logic [3:0] run_a, hold_a;
  int         sviol_a = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      wrdy_a <= '0; run_a <= '0; hold_a <= '0; prs_bus_a <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load_a[i]) begin lat_q_a[i] <= cur_lat_a; prs_q_a[i] <= cur_prs_a; end
        if (start_a[i]) begin
          if (wrdy_a[i]) sviol_a <= sviol_a + 1;
          run_a[i] <= 1'b1; cnt_a[i] <= lat_q_a[i];
        end else if (run_a[i]) begin
          if (cnt_a[i] == 0) begin
            wrdy_a[i] <= 1'b1; prs_bus_a[i*5 +: 5] <= prs_q_a[i]; run_a[i] <= 1'b0;
          end else cnt_a[i] <= cnt_a[i] - 1;
        end
        if (acc_a[i]) hold_a[i] <= 1'b1;
        if (hold_a[i]) begin wrdy_a[i] <= 1'b0; hold_a[i] <= 1'b0; end
      end
    end
  end

  int         cnt_b [2];
  int         lat_q_b [2];
  logic [4:0] prs_q_b [2];
  logic [1:0] run_b, hold_b;
  int         sviol_b = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      wrdy_b <= '0; run_b <= '0; hold_b <= '0; prs_bus_b <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load_b[i]) begin lat_q_b[i] <= cur_lat_b; prs_q_b[i] <= cur_prs_b; end
        if (start_b[i]) begin
          if (wrdy_b[i]) sviol_b <= sviol_b + 1;
          run_b[i] <= 1'b1; cnt_b[i] <= lat_q_b[i];
        end else if (run_b[i]) begin
          if (cnt_b[i] == 0) begin
            wrdy_b[i] <= 1'b1; prs_bus_b[i*5 +: 5] <= prs_q_b[i]; run_b[i] <= 1'b0;
          end else cnt_b[i] <= cnt_b[i] - 1;
        end
        if (acc_b[i]) hold_b[i] <= 1'b1;
        if (hold_b[i]) begin wrdy_b[i] <= 1'b0; hold_b[i] <= 1'b0; end
      end
    end
  end

  // Event logs and pulse monitors.
  int load_log_a[$];
  int acc_log_a[$];
  int acc_cyc_a[$];
  int accw_viol_a = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int stall_b = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    acc_prev_a <= acc_a;
    for (int i = 0; i < 4; i++) begin
      if (load_a[i]) load_log_a.push_back(i);
      if (acc_a[i]) begin acc_log_a.push_back(i); acc_cyc_a.push_back(cyc); end
      if (acc_a[i] && acc_prev_a[i]) accw_viol_a <= accw_viol_a + 1;
    end
    if (done_a) done_cnt_a <= done_cnt_a + 1;
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (rst_n && vb && !rdy_b) stall_b <= stall_b + 1;
  end

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send_a(input int prs, input int lat, input bit last);
    int n = 0;
    @(negedge clk);
    va = 1'b1; la = last; cur_prs_a = 5'(prs); cur_lat_a = lat;
    while (!rdy_a && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin checks++; $display("FAIL send_a timeout: in_ready stayed 0 for %0d cycles, required 1", n); end
    @(posedge clk); #1 va = 1'b0; la = 1'b0;
  endtask

  task automatic send_b(input int prs, input int lat, input bit last);
    int n = 0;
    @(negedge clk);
    vb = 1'b1; lb = last; cur_prs_b = 5'(prs); cur_lat_b = lat;
    while (!rdy_b && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin checks++; $display("FAIL send_b timeout: in_ready stayed 0 for %0d cycles, required 1", n); end
    @(posedge clk); #1 vb = 1'b0; lb = 1'b0;
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (done_a !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (done_a !== 1'b1) $display("FAIL wait_done_a: done=%0b after %0d cycles, required 1", done_a, n);
    else passed++;
  endtask

  task automatic wait_done_b();
    int n = 0;
    while (done_b !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++;
    if (done_b !== 1'b1) $display("FAIL wait_done_b: done=%0b after %0d cycles, required 1", done_b, n);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_a, start_a, acc_a, busy_a, done_a, rdy_a} !== 15'd0) $display("FAIL reset_ctrl_a: got %h required 0", {load_a, start_a, acc_a, busy_a, done_a, rdy_a});
    else passed++;
    checks++;
    if ({total_a, md_a, total_b, md_b} !== 40'd0) $display("FAIL reset_totals: got %h required 0", {total_a, md_a, total_b, md_b});
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy_a, rdy_b, busy_a, busy_b} !== 4'b1100) $display("FAIL reset_ready: got %b required 1100", {rdy_a, rdy_b, busy_a, busy_b});
    else passed++;
  endtask

  task automatic test_order();
    int l0, a0, d0, s0;
    int exp_load[4];
    int exp_acc[4];
    exp_load = '{0, 1, 2, 3};
    exp_acc  = '{3, 0, 2, 1};
    do_reset();
    l0 = load_log_a.size(); a0 = acc_log_a.size(); d0 = done_cnt_a; s0 = sviol_a;
    send_a(2, 6, 1'b0);
    send_a(3, 12, 1'b0);
    send_a(1, 8, 1'b0);
    send_a(4, 1, 1'b1);
    wait_done_a();
    @(negedge clk); @(negedge clk);
    checks++;
    if (total_a !== 16'd10) $display("FAIL order_total: got %0d required 10", total_a); else passed++;
    checks++;
    if (md_a !== 16'd4) $display("FAIL order_machines: got %0d required 4", md_a); else passed++;
    checks++;
    if (done_cnt_a - d0 !== 1) $display("FAIL order_done_pulses: got %0d required 1", done_cnt_a - d0); else passed++;
    checks++;
    if (load_log_a.size() - l0 !== 4 || acc_log_a.size() - a0 !== 4)
      $display("FAIL order_counts: loads %0d accepts %0d required 4 and 4", load_log_a.size() - l0, acc_log_a.size() - a0);
    else begin
      passed++;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (load_log_a[l0+k] !== exp_load[k]) $display("FAIL order_load[%0d]: got worker %0d required %0d", k, load_log_a[l0+k], exp_load[k]);
        else passed++;
        checks++;
        if (acc_log_a[a0+k] !== exp_acc[k]) $display("FAIL order_accept[%0d]: got worker %0d required %0d", k, acc_log_a[a0+k], exp_acc[k]);
        else passed++;
      end
    end
    checks++;
    if (sviol_a - s0 !== 0) $display("FAIL order_start_while_ready: got %0d required 0", sviol_a - s0); else passed++;
  endtask

  task automatic test_simultaneous();
    int a0, w0;
    do_reset();
    a0 = acc_log_a.size(); w0 = accw_viol_a;
    send_a(5, 3, 1'b0);
    send_a(6, 2, 1'b1);
    wait_done_a();
    @(negedge clk);
    checks++;
    if (acc_log_a.size() - a0 !== 2) $display("FAIL simul_count: got %0d accepts required 2", acc_log_a.size() - a0);
    else begin
      passed++;
      checks++;
      if (acc_log_a[a0] !== 0 || acc_log_a[a0+1] !== 1) $display("FAIL simul_order: got %0d,%0d required 0,1", acc_log_a[a0], acc_log_a[a0+1]);
      else passed++;
      checks++;
      if (acc_cyc_a[a0+1] - acc_cyc_a[a0] !== 1) $display("FAIL simul_gap: got %0d cycles required 1", acc_cyc_a[a0+1] - acc_cyc_a[a0]);
      else passed++;
    end
    checks++;
    if (accw_viol_a - w0 !== 0) $display("FAIL simul_accept_width: got %0d wide pulses required 0", accw_viol_a - w0); else passed++;
    checks++;
    if (total_a !== 16'd11) $display("FAIL simul_total: got %0d required 11", total_a); else passed++;
  endtask

  task automatic test_single_last();
    do_reset();
    send_a(7, 2, 1'b1);
    @(negedge clk);
    checks++;
    if ({busy_a, rdy_a} !== 2'b10) $display("FAIL single_flush: busy,in_ready got %b required 10", {busy_a, rdy_a}); else passed++;
    wait_done_a();
    @(negedge clk); @(negedge clk);
    checks++;
    if (total_a !== 16'd7 || md_a !== 16'd1) $display("FAIL single_hold: total %0d machines %0d required 7 and 1", total_a, md_a); else passed++;
    send_a(3, 1, 1'b1);
    @(negedge clk);
    checks++;
    if (total_a !== 16'd0 || md_a !== 16'd0) $display("FAIL single_clear: total %0d machines %0d required 0 and 0", total_a, md_a); else passed++;
    wait_done_a();
    @(negedge clk);
    checks++;
    if (total_a !== 16'd3 || md_a !== 16'd1) $display("FAIL single_rerun: total %0d machines %0d required 3 and 1", total_a, md_a); else passed++;
  endtask

  task automatic test_reset_mid();
    int a0;
    do_reset();
    send_a(1, 1, 1'b0);
    send_a(2, 60, 1'b0);
    send_a(3, 60, 1'b0);
    send_a(4, 60, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (md_a !== 16'd1 || busy_a !== 1'b1) $display("FAIL midrst_before: machines %0d busy %0b required 1 and 1", md_a, busy_a); else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({load_a, start_a, acc_a, busy_a, done_a, rdy_a} !== 15'd0) $display("FAIL midrst_ctrl: got %h required 0", {load_a, start_a, acc_a, busy_a, done_a, rdy_a}); else passed++;
    checks++;
    if (total_a !== 16'd0 || md_a !== 16'd0) $display("FAIL midrst_totals: total %0d machines %0d required 0 and 0", total_a, md_a); else passed++;
    a0 = acc_log_a.size();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (acc_log_a.size() !== a0 || busy_a !== 1'b0) $display("FAIL midrst_after: extra accepts %0d busy %0b required 0 and 0", acc_log_a.size() - a0, busy_a); else passed++;
  endtask

  task automatic test_back_to_back();
    int st0, d0, s0;
    do_reset();
    st0 = stall_b; d0 = done_cnt_b; s0 = sviol_b;
    send_b(1, 2, 1'b0);
    send_b(2, 2, 1'b0);
    send_b(1, 2, 1'b0);
    send_b(3, 2, 1'b0);
    send_b(2, 2, 1'b1);
    wait_done_b();
    @(negedge clk); @(negedge clk);
    checks++;
    if (!(stall_b - st0 > 0)) $display("FAIL b2b_stall: in_ready low cycles %0d required >0", stall_b - st0); else passed++;
    checks++;
    if (sviol_b - s0 !== 0) $display("FAIL b2b_start_while_ready: got %0d required 0", sviol_b - s0); else passed++;
    checks++;
    if (total_b !== 4'd9 || md_b !== 4'd5) $display("FAIL b2b_totals: total %0d machines %0d required 9 and 5", total_b, md_b); else passed++;
    checks++;
    if (done_cnt_b - d0 !== 1) $display("FAIL b2b_done_pulses: got %0d required 1", done_cnt_b - d0); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    send_b(7, 1, 1'b0);
    send_b(7, 1, 1'b0);
    send_b(7, 1, 1'b1);
    wait_done_b();
    @(negedge clk);
    checks++;
    if (total_b !== 4'd15) $display("FAIL sat_total: got %0d required 15", total_b); else passed++;
    checks++;
    if (md_b !== 4'd3) $display("FAIL sat_machines: got %0d required 3", md_b); else passed++;
  endtask

  initial begin
    test_reset();
    test_order();
    test_simultaneous();
    test_single_last();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
